// File: rtl/fft_output_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_output_reorder
// Purpose  : Ping-pong reorder buffer behind the last radix-2 FFT stage.
//            One bank is filled in bit-reversed order. At the same time the
//            other bank is read out in natural order, so the block sustains
//            one sample per clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   In_valid   in   Low_in_re/Low_in_im carry a sample this cycle
//   Low_in_re  in   DW-bit real part, bit-reversed order
//   Low_in_im  in   DW-bit imaginary part, bit-reversed order
//   Out_valid  out  Out_re/Out_im/Out_index valid this cycle
//   Out_re     out  DW-bit real part, natural order
//   Out_im     out  DW-bit imaginary part, natural order
//   Out_index  out  natural-order bin number
//   Out_sof    out  high with bin 0 of each output frame
//   Sat_flag   out  sticky saturation indicator (FFT_REORDER_SAT16_EN only)
// Configuration
//   FFT_REORDER_SAT16_EN : when defined, the outputs are clipped to the
//                          signed 16-bit range, sign-extended to DW bits,
//                          and the Sat_flag port is added.
// ============================================================================
module fft_output_reorder #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int DW    = 17
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_valid,
    input  logic [DW-1:0]    Low_in_re,
    input  logic [DW-1:0]    Low_in_im,
    output logic             Out_valid,
    output logic [DW-1:0]    Out_re,
    output logic [DW-1:0]    Out_im,
    output logic [LOG2N-1:0] Out_index,
    output logic             Out_sof
`ifdef FFT_REORDER_SAT16_EN
    ,
    output logic             Sat_flag
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int k = 0; k < LOG2N; k++) begin
            r[k] = a[LOG2N-1-k];
        end
        return r;
    endfunction

`ifdef FFT_REORDER_SAT16_EN
    // Returns {saturated, value}. A value fits in 16 bits when bits
    // [DW-1:15] are all copies of the sign bit.
    function automatic logic [DW:0] sat16(input logic [DW-1:0] x);
        if ((x[DW-1:15] == '0) || (x[DW-1:15] == '1)) begin
            return {1'b0, x};
        end else if (x[DW-1]) begin
            return {1'b1, {(DW-15){1'b1}}, 15'h0000};
        end else begin
            return {1'b1, {(DW-15){1'b0}}, 15'h7fff};
        end
    endfunction
`endif

    // Buffer RAM: bank bit is the MSB of the address; never reset.
    logic [2*DW-1:0]  mem_q [0:2*N-1];

    logic [LOG2N-1:0] wr_cnt_q;
    logic             wr_bank_q;
    state_t           state_q;
    logic [LOG2N-1:0] rd_cnt_q;
    logic             rd_bank_q;
    logic             out_valid_q;
    logic [DW-1:0]    out_re_q;
    logic [DW-1:0]    out_im_q;
    logic [LOG2N-1:0] out_index_q;
    logic             out_sof_q;

    logic             frame_done;
    logic [LOG2N:0]   wr_addr;
    logic [2*DW-1:0]  rd_word;
    logic [DW-1:0]    re_d;
    logic [DW-1:0]    im_d;
    logic             sat_hit;

    assign frame_done = In_valid && (wr_cnt_q == LOG2N'(N-1));
    assign wr_addr    = {wr_bank_q, bitrev(wr_cnt_q)};
    assign rd_word    = mem_q[{rd_bank_q, rd_cnt_q}];

`ifdef FFT_REORDER_SAT16_EN
    logic [DW:0] sat_re;
    logic [DW:0] sat_im;
    logic        sat_flag_q;

    assign sat_re   = sat16(rd_word[2*DW-1:DW]);
    assign sat_im   = sat16(rd_word[DW-1:0]);
    assign re_d     = sat_re[DW-1:0];
    assign im_d     = sat_im[DW-1:0];
    assign sat_hit  = sat_re[DW] | sat_im[DW];
    assign Sat_flag = sat_flag_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sat_flag_q <= 1'b0;
        end else if ((state_q == S_READ) && sat_hit) begin
            sat_flag_q <= 1'b1;
        end
    end
`else
    assign re_d    = rd_word[2*DW-1:DW];
    assign im_d    = rd_word[DW-1:0];
    assign sat_hit = 1'b0;
`endif

    // RAM write port. Writes are suppressed while in reset, because the
    // write pointer is held there.
    always_ff @(posedge Clk) begin
        if (In_valid && !Reset) begin
            mem_q[wr_addr] <= {Low_in_re, Low_in_im};
        end
    end

    // Write pointer and bank. The counter wraps naturally modulo N.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (In_valid) begin
            wr_cnt_q <= wr_cnt_q + LOG2N'(1);
            if (frame_done) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    // Read FSM with registered outputs. The RAM read and the output
    // register are the same stage, so bin i leaves one cycle after
    // rd_cnt = i. The bank just completed is wr_bank_q before it toggles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_index_q <= '0;
            out_sof_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_done) begin
                        state_q   <= S_READ;
                        rd_bank_q <= wr_bank_q;
                        rd_cnt_q  <= '0;
                    end
                end
                S_READ: begin
                    out_valid_q <= 1'b1;
                    out_re_q    <= re_d;
                    out_im_q    <= im_d;
                    out_index_q <= rd_cnt_q;
                    out_sof_q   <= (rd_cnt_q == '0);
                    rd_cnt_q    <= rd_cnt_q + LOG2N'(1);
                    if (rd_cnt_q == LOG2N'(N-1)) begin
                        if (frame_done) begin
                            rd_bank_q <= wr_bank_q;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Out_valid = out_valid_q;
    assign Out_re    = out_re_q;
    assign Out_im    = out_im_q;
    assign Out_index = out_index_q;
    assign Out_sof   = out_sof_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_output_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_output_reorder
// Purpose  : Directed self-checking bench for fft_output_reorder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_output_reorder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_valid;
    logic [16:0] Low_in_re;
    logic [16:0] Low_in_im;
    logic        Out_valid;
    logic [16:0] Out_re;
    logic [16:0] Out_im;
    logic [4:0]  Out_index;
    logic        Out_sof;
`ifdef FFT_REORDER_SAT16_EN
    logic        Sat_flag;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sof_stray = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [16:0] re;
        logic [16:0] im;
        logic        sof;
    } ent_t;
    ent_t mon_q[$];

    fft_output_reorder #(.N(32), .LOG2N(5), .DW(17)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_valid  (In_valid),
        .Low_in_re (Low_in_re),
        .Low_in_im (Low_in_im),
        .Out_valid (Out_valid),
        .Out_re    (Out_re),
        .Out_im    (Out_im),
        .Out_index (Out_index),
        .Out_sof   (Out_sof)
`ifdef FFT_REORDER_SAT16_EN
        ,
        .Sat_flag  (Sat_flag)
`endif
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Out_valid) begin
            ent_t e;
            e.cyc = cyc;
            e.idx = Out_index;
            e.re  = Out_re;
            e.im  = Out_im;
            e.sof = Out_sof;
            mon_q.push_back(e);
        end else if (Out_sof === 1'b1) begin
            sof_stray++;
        end
    end

    function automatic logic [4:0] br5(input int v);
        logic [4:0] b;
        b = 5'(v);
        return {b[0], b[1], b[2], b[3], b[4]};
    endfunction

    // One input cycle; the sample occupies the cycle numbered cyc on return.
    task automatic send(input logic v, input logic [16:0] re, input logic [16:0] im);
        @(posedge Clk);
        #1;
        In_valid  = v;
        Low_in_re = re;
        Low_in_im = im;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 17'd0, 17'd0);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk);
            #1;
            In_valid  = 1'b1;
            Low_in_re = 17'($urandom);
            Low_in_im = 17'($urandom);
            @(negedge Clk);
            total++;
            if (Out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", Out_valid); end
            total++;
            if (Out_re !== 17'd0 || Out_im !== 17'd0) begin
                bad++; $display("FAIL reset_data got re=%h im=%h exp=0", Out_re, Out_im);
            end
            total++;
            if (Out_index !== 5'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", Out_index); end
        end
        @(posedge Clk);
        #1;
        Reset    = 1'b0;
        In_valid = 1'b0;
        idle(3);
        total++;
        if (mon_q.size() != 0) begin bad++; $display("FAIL reset_no_output got=%0d exp=0", mon_q.size()); end
    endtask

    task automatic test_single_frame;
        int t0;
        logic [16:0] v;
        mon_q.delete();
        sof_stray = 0;
        for (int j = 0; j < 32; j++) begin
            v = 17'(br5(j));
            send(1'b1, v, 17'd0 - v);
            if (j == 0) t0 = cyc;
        end
        idle(40);
        total++;
        if (mon_q.size() != 32) begin bad++; $display("FAIL single_count got=%0d exp=32", mon_q.size()); end
        for (int i = 0; i < 32 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].idx !== 5'(i) || mon_q[i].re !== 17'(i) || mon_q[i].im !== 17'd0 - 17'(i)) begin
                bad++;
                $display("FAIL single_bin%0d got idx=%0d re=%h im=%h exp idx=%0d re=%h im=%h",
                         i, mon_q[i].idx, mon_q[i].re, mon_q[i].im, i, 17'(i), 17'd0 - 17'(i));
            end
            total++;
            if (mon_q[i].cyc != t0 + 33 + i) begin
                bad++; $display("FAIL single_time%0d got=%0d exp=%0d", i, mon_q[i].cyc, t0 + 33 + i);
            end
            total++;
            if (mon_q[i].sof !== (i == 0)) begin
                bad++; $display("FAIL single_sof%0d got=%b exp=%b", i, mon_q[i].sof, (i == 0));
            end
        end
        total++;
        if (sof_stray != 0) begin bad++; $display("FAIL single_stray_sof got=%0d exp=0", sof_stray); end
    endtask

    task automatic test_back_to_back;
        int t0;
        int k;
        int i;
        mon_q.delete();
        for (int n = 0; n < 96; n++) begin
            send(1'b1, 17'(100 * (n / 32)) + 17'(br5(n % 32)), 17'd0);
            if (n == 0) t0 = cyc;
        end
        idle(40);
        total++;
        if (mon_q.size() != 96) begin bad++; $display("FAIL b2b_count got=%0d exp=96", mon_q.size()); end
        for (int n = 0; n < 96 && n < mon_q.size(); n++) begin
            k = n / 32;
            i = n % 32;
            total++;
            if (mon_q[n].idx !== 5'(i) || mon_q[n].re !== 17'(100 * k + i) || mon_q[n].im !== 17'd0 ||
                mon_q[n].sof !== (i == 0) || mon_q[n].cyc != t0 + 33 + n) begin
                bad++;
                $display("FAIL b2b_out%0d got idx=%0d re=%0d im=%0d sof=%b cyc=%0d exp idx=%0d re=%0d im=0 sof=%b cyc=%0d",
                         n, mon_q[n].idx, mon_q[n].re, mon_q[n].im, mon_q[n].sof, mon_q[n].cyc,
                         i, 100 * k + i, (i == 0), t0 + 33 + n);
            end
        end
    endtask

    task automatic test_gapped;
        int last;
        logic [16:0] v;
        mon_q.delete();
        for (int j = 0; j < 32; j++) begin
            v = 17'(br5(j));
            send(1'b1, v, 17'd0 - v);
            last = cyc;
            if (j != 31) send(1'b0, 17'h1ffff, 17'h1ffff);
        end
        idle(40);
        total++;
        if (mon_q.size() != 32) begin bad++; $display("FAIL gap_count got=%0d exp=32", mon_q.size()); end
        if (mon_q.size() > 0) begin
            total++;
            if (mon_q[0].cyc != last + 2) begin
                bad++; $display("FAIL gap_latency got=%0d exp=%0d", mon_q[0].cyc, last + 2);
            end
        end
        for (int i = 0; i < 32 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].idx !== 5'(i) || mon_q[i].re !== 17'(i) || mon_q[i].im !== 17'd0 - 17'(i) ||
                mon_q[i].sof !== (i == 0) || mon_q[i].cyc != last + 2 + i) begin
                bad++;
                $display("FAIL gap_bin%0d got idx=%0d re=%h im=%h cyc=%0d exp idx=%0d re=%h im=%h cyc=%0d",
                         i, mon_q[i].idx, mon_q[i].re, mon_q[i].im, mon_q[i].cyc,
                         i, 17'(i), 17'd0 - 17'(i), last + 2 + i);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int t0;
        for (int j = 0; j < 17; j++) send(1'b1, 17'h00123, 17'h00456);
        @(posedge Clk);
        #1;
        Reset    = 1'b1;
        In_valid = 1'b0;
        mon_q.delete();
        @(negedge Clk);
        total++;
        if (Out_valid !== 1'b0 || Out_re !== 17'd0 || Out_im !== 17'd0) begin
            bad++; $display("FAIL midrst_outputs got v=%b re=%h im=%h exp 0 0 0", Out_valid, Out_re, Out_im);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int j = 0; j < 32; j++) begin
            send(1'b1, 17'd7, 17'd0 - 17'd7);
            if (j == 0) t0 = cyc;
        end
        idle(40);
        total++;
        if (mon_q.size() != 32) begin bad++; $display("FAIL midrst_count got=%0d exp=32", mon_q.size()); end
        for (int i = 0; i < 32 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].idx !== 5'(i) || mon_q[i].re !== 17'd7 || mon_q[i].im !== 17'h1fff9 ||
                mon_q[i].cyc != t0 + 33 + i) begin
                bad++;
                $display("FAIL midrst_bin%0d got idx=%0d re=%h im=%h cyc=%0d exp idx=%0d re=00007 im=1fff9 cyc=%0d",
                         i, mon_q[i].idx, mon_q[i].re, mon_q[i].im, mon_q[i].cyc, i, t0 + 33 + i);
            end
        end
    endtask

`ifdef FFT_REORDER_SAT16_EN
    task automatic test_sat;
        total++;
        if (Sat_flag !== 1'b0) begin bad++; $display("FAIL sat_initial got=%b exp=0", Sat_flag); end
        mon_q.delete();
        for (int j = 0; j < 32; j++) begin
            if (j == 0) send(1'b1, 17'h09C40, 17'h163C0);
            else        send(1'b1, 17'd3, 17'd0 - 17'd3);
        end
        idle(40);
        total++;
        if (mon_q.size() != 32) begin bad++; $display("FAIL sat_count got=%0d exp=32", mon_q.size()); end
        if (mon_q.size() > 1) begin
            total++;
            if (mon_q[0].re !== 17'h07FFF || mon_q[0].im !== 17'h18000) begin
                bad++; $display("FAIL sat_bin0 got re=%h im=%h exp re=07fff im=18000", mon_q[0].re, mon_q[0].im);
            end
            total++;
            if (mon_q[1].re !== 17'd3 || mon_q[1].im !== 17'h1fffd) begin
                bad++; $display("FAIL sat_bin1 got re=%h im=%h exp re=00003 im=1fffd", mon_q[1].re, mon_q[1].im);
            end
        end
        total++;
        if (Sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", Sat_flag); end
        idle(10);
        total++;
        if (Sat_flag !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", Sat_flag); end
    endtask
`endif

    initial begin
        Reset     = 1'b1;
        In_valid  = 1'b0;
        Low_in_re = '0;
        Low_in_im = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
`ifdef FFT_REORDER_SAT16_EN
        test_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
